// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core: opcodes, sequencer states and
// instruction field positions.
package core_pkg;

    localparam logic [1:0] OP_LI   = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_ILL  = 2'b10;
    localparam logic [1:0] OP_J    = 2'b11;

    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 3;
    localparam int IMM_MSB = 2;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_HALT
    } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/write-back bus between the sequencer (master) and the core environment
// (instruction memory, register file, run/step controls).
interface pc_sequencer_if #(parameter int PC_W = 8);
    logic            run;
    logic            step;
    logic [7:0]      inst_code;
    logic            wb_ready;
    logic [PC_W-1:0] pc_out;
    logic            rf_we;
    logic [2:0]      rf_waddr;
    logic [7:0]      rf_imm;
    logic            rf_add;
    logic            halted;
    logic            illegal;

    modport master (
        input  run, step, inst_code, wb_ready,
        output pc_out, rf_we, rf_waddr, rf_imm, rf_add, halted, illegal
    );

    modport slave (
        output run, step, inst_code, wb_ready,
        input  pc_out, rf_we, rf_waddr, rf_imm, rf_add, halted, illegal
    );
endinterface

// File: rtl/pc_sequencer_inst_decoder.sv
// Combinational field extraction for one instruction byte.
module inst_decoder
    import core_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [7:0]      i_ir,
    output logic [1:0]      o_op,
    output logic [2:0]      o_rd,
    output logic [7:0]      o_imm,
    output logic [PC_W-1:0] o_tgt
);
    assign o_op  = i_ir[7:6];
    assign o_rd  = i_ir[RD_MSB:RD_LSB];
    assign o_imm = {{5{i_ir[IMM_MSB]}}, i_ir[IMM_MSB:IMM_LSB]};
    // Jump target is the whole low 6 bits, overlapping rd and imm.
    assign o_tgt = PC_W'(i_ir[5:0]);
endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller: owns the PC, the instruction register and
// the registered register-file write port.
module pc_sequencer
    import core_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int MEM_DEPTH = 8
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.master bus
);
    localparam logic [PC_W:0] MEM_END = (PC_W+1)'(MEM_DEPTH);

    state_t          r_state;
    logic [7:0]      r_ir;
    logic [PC_W-1:0] r_pc;
    logic            r_we;
    logic [2:0]      r_waddr;
    logic [7:0]      r_imm;
    logic            r_add;
    logic            r_halted;
    logic            r_ill;

    logic [1:0]      w_op;
    logic [2:0]      w_rd;
    logic [7:0]      w_imm;
    logic [PC_W-1:0] w_tgt;
    logic            w_end;

    inst_decoder #(.PC_W(PC_W)) u_dec (
        .i_ir  (r_ir),
        .o_op  (w_op),
        .o_rd  (w_rd),
        .o_imm (w_imm),
        .o_tgt (w_tgt)
    );

    // Extra bit lets MEM_DEPTH = 2^PC_W mean "never ends, PC wraps".
    assign w_end = {1'b0, r_pc} >= MEM_END;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_ir     <= '0;
            r_pc     <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_imm    <= '0;
            r_add    <= 1'b0;
            r_halted <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_end) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (bus.run || bus.step) begin
                        r_ir    <= bus.inst_code;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_waddr <= w_rd;
                    r_imm   <= w_imm;
                    r_add   <= (w_op == OP_ADDI);
                    if (w_op == OP_ILL) begin
                        r_ill    <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_we    <= (w_op != OP_J);
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC, S_WAIT: begin
                    if (w_op == OP_J) begin
                        r_pc    <= w_tgt;
                        r_state <= S_FETCH;
                    end else if (bus.wb_ready) begin
                        r_we    <= 1'b0;
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign bus.pc_out   = r_pc;
    assign bus.rf_we    = r_we;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_imm   = r_imm;
    assign bus.rf_add   = r_add;
    assign bus.halted   = r_halted;
    assign bus.illegal  = r_ill;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed program table, hand-written multi-cycle
// sequences and random programs checked against an ISA-level model.
module tb_pc_sequencer;
    typedef logic [0:7][7:0] prog_t;

    typedef struct {
        string            name;
        prog_t            prog;
        int               exp_pc;
        bit               exp_ill;
        int               exp_n;
        logic [0:7][11:0] exp_w;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] imem [256];
    int tests = 0;
    int fails = 0;
    logic [11:0] wq [$];
    logic [11:0] exp_q [$];

    pc_sequencer_if #(.PC_W(8)) bus ();

    pc_sequencer #(.PC_W(8), .MEM_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.inst_code = imem[bus.pc_out];

    // Accepted writes, one per cycle where the strobe meets ready.
    logic        prev_stall = 1'b0;
    logic [11:0] prev_f = '0;
    always @(posedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                tests++;
                if (!(bus.rf_we && {bus.rf_waddr, bus.rf_imm, bus.rf_add} == prev_f)) begin
                    fails++;
                    $display("FAIL stall_hold: we=%0b fields=%03h required we=1 fields=%03h",
                             bus.rf_we, {bus.rf_waddr, bus.rf_imm, bus.rf_add}, prev_f);
                end
            end
            if (bus.rf_we && bus.wb_ready) wq.push_back({bus.rf_waddr, bus.rf_imm, bus.rf_add});
            prev_stall = bus.rf_we && !bus.wb_ready;
            prev_f     = {bus.rf_waddr, bus.rf_imm, bus.rf_add};
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [11:0] W(input int rd, input logic [7:0] imm, input bit add);
        return {3'(rd), imm, add};
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endfunction

    // ISA-level reference: walks the program, collecting the writes it retires.
    task automatic model(input prog_t p, output int epc, output bit eill);
        int pc = 0;
        eill = 0;
        exp_q.delete();
        for (int n = 0; n < 64; n++) begin
            logic [7:0] b;
            int v;
            if (pc >= 8) break;
            b = p[pc];
            v = int'(b[2:0]);
            if (v > 3) v -= 8;
            if (b[7:6] == 2'b10) begin
                eill = 1;
                break;
            end else if (b[7:6] == 2'b11) begin
                pc = int'(b[5:0]);
            end else begin
                exp_q.push_back(W(int'(b[5:3]), 8'(v), b[6]));
                pc = (pc + 1) % 256;
            end
        end
        epc = pc;
    endtask

    task automatic start(input prog_t p, input bit run_v, input bit rdy);
        reset = 1'b1;
        bus.run = run_v;
        bus.step = 1'b0;
        bus.wb_ready = rdy;
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        for (int i = 0; i < 8; i++) imem[i] = p[i];
        repeat (2) @(negedge clk);
        wq.delete();
        reset = 1'b0;
    endtask

    task automatic wait_halt(input bit rnd, output bit ok);
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.halted) begin
                ok = 1;
                break;
            end
            if (rnd) bus.wb_ready = ($urandom_range(0, 3) != 0);
        end
        bus.wb_ready = 1'b1;
    endtask

    task automatic compare(input string nm, input bit ok, input int epc, input bit eill);
        chk({nm, "_halt_in_time"}, 32'(ok), 1);
        chk({nm, "_nwrites"}, wq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
            chk($sformatf("%s_w%0d", nm, i), 32'(wq[i]), 32'(exp_q[i]));
        chk({nm, "_pc"}, 32'(bus.pc_out), epc);
        chk({nm, "_illegal"}, 32'(bus.illegal), 32'(eill));
        chk({nm, "_we_off"}, 32'(bus.rf_we), 0);
    endtask

    vec_t  vt [4];
    prog_t p;
    bit    ok;
    int    epc;
    bit    eill;

    initial begin
        vt[0] = '{"prog1", {8'h13, 8'h52, 8'h6B, 8'hC5, 8'h29, 8'h6D, 8'h00, 8'h00}, 8, 0, 6,
                  {W(2, 8'h03, 0), W(2, 8'h02, 1), W(5, 8'h03, 1), W(5, 8'hFD, 1),
                   W(0, 8'h00, 0), W(0, 8'h00, 0), 12'h0, 12'h0}};
        vt[1] = '{"illegal", {8'h80, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 0,
                  {12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};
        vt[2] = '{"jump63", {8'hFF, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 63, 0, 0,
                  {12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};
        vt[3] = '{"neg4_j8", {8'h3C, 8'hC8, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8, 0, 1,
                  {W(7, 8'hFC, 0), 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};

        // Reset state
        bus.run = 1'b0; bus.step = 1'b0; bus.wb_ready = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        #1;
        chk("rst_pc", 32'(bus.pc_out), 0);
        chk("rst_we", 32'(bus.rf_we), 0);
        chk("rst_waddr", 32'(bus.rf_waddr), 0);
        chk("rst_imm", 32'(bus.rf_imm), 0);
        chk("rst_add", 32'(bus.rf_add), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_illegal", 32'(bus.illegal), 0);

        // Directed table
        for (int v = 0; v < 4; v++) begin
            start(vt[v].prog, 1'b1, 1'b1);
            wait_halt(1'b0, ok);
            exp_q.delete();
            for (int i = 0; i < vt[v].exp_n; i++) exp_q.push_back(vt[v].exp_w[i]);
            compare(vt[v].name, ok, vt[v].exp_pc, vt[v].exp_ill);
        end

        // Halt is sticky against step pulses
        start({8'h80, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1);
        wait_halt(1'b0, ok);
        bus.run = 1'b0;
        repeat (3) begin
            bus.step = 1'b1; @(negedge clk); bus.step = 1'b0; repeat (3) @(negedge clk);
        end
        chk("ill_step_halted", 32'(bus.halted), 1);
        chk("ill_step_illegal", 32'(bus.illegal), 1);
        chk("ill_step_pc", 32'(bus.pc_out), 0);
        chk("ill_step_nw", wq.size(), 0);

        // Write held under back-pressure for 4 cycles
        start({8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rf_we) begin ok = 1; break; end
        end
        chk("stall_we_seen", 32'(ok), 1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_we_c%0d", k), 32'(bus.rf_we), 1);
            chk($sformatf("stall_f_c%0d", k), 32'({bus.rf_waddr, bus.rf_imm, bus.rf_add}),
                32'(W(2, 8'h03, 0)));
            chk($sformatf("stall_pc_c%0d", k), 32'(bus.pc_out), 0);
            if (k == 4) bus.wb_ready = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        chk("stall_we_drop", 32'(bus.rf_we), 0);
        chk("stall_pc_adv", 32'(bus.pc_out), 1);
        chk("stall_nw", wq.size(), 1);

        // Single-step mode: three pulses, the first one stretched into DECODE
        start({8'h09, 8'h12, 8'h1B, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("step_idle_nw", wq.size(), 0);
        chk("step_idle_pc", 32'(bus.pc_out), 0);
        for (int s = 0; s < 3; s++) begin
            bus.step = 1'b1;
            @(negedge clk);
            if (s == 0) @(negedge clk);
            bus.step = 1'b0;
            repeat (10) @(negedge clk);
            chk($sformatf("step%0d_nw", s), wq.size(), s + 1);
            chk($sformatf("step%0d_pc", s), 32'(bus.pc_out), s + 1);
        end
        if (wq.size() == 3) begin
            chk("step_w0", 32'(wq[0]), 32'(W(1, 8'h01, 0)));
            chk("step_w2", 32'(wq[2]), 32'(W(3, 8'h03, 0)));
        end

        // Asynchronous reset while a write is held
        start({8'h13, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        chk("rw_in_wait", 32'(bus.rf_we), 1);
        #2 reset = 1'b1;
        #1;
        chk("rw_we", 32'(bus.rf_we), 0);
        chk("rw_pc", 32'(bus.pc_out), 0);
        chk("rw_fields", 32'({bus.rf_waddr, bus.rf_imm, bus.rf_add}), 0);
        chk("rw_flags", 32'({bus.halted, bus.illegal}), 0);
        chk("rw_nw", wq.size(), 0);
        bus.wb_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_restart_pc", 32'(bus.pc_out), 0);
        repeat (4) @(negedge clk);
        chk("rw_restart_nw", wq.size(), 1);
        if (wq.size() > 0) chk("rw_restart_w", 32'(wq[0]), 32'(W(2, 8'h03, 0)));

        // Random forward-jumping programs with random back-pressure
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 8; i++) begin
                int r = $urandom_range(0, 19);
                if (r == 0) p[i] = {2'b10, 6'($urandom)};
                else if (r < 5) begin
                    int tg = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(i + 1, 9);
                    p[i] = {2'b11, 6'(tg)};
                end else p[i] = {1'b0, 7'($urandom)};
            end
            model(p, epc, eill);
            start(p, 1'b1, 1'b1);
            wait_halt(1'b1, ok);
            compare($sformatf("rnd%0d", t), ok, epc, eill);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
